// File: rtl/lcd_wb_regs_pkg.sv
// Shared definitions for the LCD Wishbone register block.
// Register offsets, CTRL bit positions, cursor geometry, bus states.
package lcd_wb_regs_pkg;

  localparam int CUR_W    = 5;
  localparam int ROW_NIBS = 16;

  localparam logic [3:0] ADR_M2   = 4'h9;
  localparam logic [3:0] ADR_CTRL = 4'hA;
  localparam logic [3:0] ADR_CON  = 4'hB;
  localparam logic [3:0] ADR_CUR  = 4'hC;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_CLEAR  = 2;
  localparam int CTRL_NL     = 3;

  localparam logic [CUR_W-1:0] ROW2_P = CUR_W'(ROW_NIBS);

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_t;

  // Byte-lane merge of a 16-bit register word.
  function automatic logic [15:0] merge16(
    input logic [15:0] old_v,
    input logic [15:0] new_v,
    input logic [1:0]  sel
  );
    merge16 = old_v;
    if (sel[0]) merge16[7:0]  = new_v[7:0];
    if (sel[1]) merge16[15:8] = new_v[15:8];
  endfunction

endpackage

// File: rtl/lcd_nib_wr.sv
// Writes one hex nibble at cursor p into a {row1,row2} buffer.
// Cursor p maps to nibble 31-p and mask bit 31-p; sets that mask bit.
module lcd_nib_wr
  import lcd_wb_regs_pkg::*;
(
  input  logic [127:0]     f_i,
  input  logic [31:0]      m_i,
  input  logic [CUR_W-1:0] p,
  input  logic [3:0]       nib,
  output logic [127:0]     f_o,
  output logic [31:0]      m_o
);

  logic [CUR_W-1:0] idx;

  // 31-p for a 5-bit cursor is its bitwise complement.
  assign idx = ~p;

  // Patch the selected nibble and mark it visible.
  always_comb begin
    f_o = f_i;
    m_o = m_i;
    f_o[{idx, 2'b00} +: 4] = nib;
    m_o[idx] = 1'b1;
  end

endmodule

// File: rtl/lcd_wb_regs.sv
// Wishbone slave holding the shadow and live 2x16 hex LCD buffers.
// Optional row scrolling on console overflow: define LCD_WB_SCROLL_EN.
module lcd_wb_regs
  import lcd_wb_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [63:0] f1,
  output logic [63:0] f2,
  output logic [15:0] m1,
  output logic [15:0] m2
);

  bus_state_t state;

  logic [127:0]     sh_f, sh_f_n, live_f;
  logic [31:0]      sh_m, sh_m_n, live_m;
  logic [CUR_W-1:0] cursor, cur_n;
  logic             autocommit, ac_n;
  logic             dirty, dirty_n;
  logic             commit_pend, commit_n;
  logic             mod;

  logic             req, wr_fire;
  logic             is_word, is_ctrl, is_con, is_cur;
  logic [2:0]       wi;
  logic [15:0]      rdata;

  logic [127:0]     nb_in_f, nb_f;
  logic [31:0]      nb_in_m, nb_m;
  logic [CUR_W-1:0] nb_p;

`ifdef LCD_WB_SCROLL_EN
  logic             scroll_pend, pend_n;
`endif

  assign req     = wb_cyc_i & wb_stb_i;
  assign wr_fire = (state == BUS_ACK) & req & wb_we_i;

  assign is_word = wb_adr_i <= ADR_M2;
  assign is_ctrl = wb_adr_i == ADR_CTRL;
  assign is_con  = wb_adr_i == ADR_CON;
  assign is_cur  = wb_adr_i == ADR_CUR;

  // Word 0-3 is f1 (upper half), 4-7 is f2: flip adr[2].
  assign wi = {~wb_adr_i[2], wb_adr_i[1:0]};

`ifdef LCD_WB_SCROLL_EN
  assign nb_in_f = scroll_pend ? {sh_f[63:0], 64'd0} : sh_f;
  assign nb_in_m = scroll_pend ? {sh_m[15:0], 16'd0} : sh_m;
  assign nb_p    = scroll_pend ? ROW2_P : cursor;
`else
  assign nb_in_f = sh_f;
  assign nb_in_m = sh_m;
  assign nb_p    = cursor;
`endif

  lcd_nib_wr u_nib (
    .f_i (nb_in_f),
    .m_i (nb_in_m),
    .p   (nb_p),
    .nib (wb_dat_i[3:0]),
    .f_o (nb_f),
    .m_o (nb_m)
  );

  assign f1 = live_f[127:64];
  assign f2 = live_f[63:0];
  assign m1 = live_m[31:16];
  assign m2 = live_m[15:0];

  // Read mux, sampled into wb_dat_o when the access is accepted.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_word: begin
        if (wb_adr_i[3])
          rdata = wb_adr_i[0] ? sh_m[15:0] : sh_m[31:16];
        else
          rdata = sh_f[{wi, 4'b0000} +: 16];
      end
      is_ctrl: rdata = {14'd0, dirty, autocommit};
      is_cur:  rdata = {11'd0, cursor};
      default: rdata = '0;
    endcase
  end

  // Write side effects; CTRL order is clear, newline, commit.
  always_comb begin
    sh_f_n   = sh_f;
    sh_m_n   = sh_m;
    cur_n    = cursor;
    ac_n     = autocommit;
    dirty_n  = dirty;
    commit_n = 1'b0;
    mod      = 1'b0;
`ifdef LCD_WB_SCROLL_EN
    pend_n   = scroll_pend;
`endif
    if (wr_fire) begin
      unique case (1'b1)
        is_word: begin
          if (wb_adr_i[3]) begin
            if (wb_adr_i[0])
              sh_m_n[15:0] = merge16(sh_m[15:0], wb_dat_i, wb_sel_i);
            else
              sh_m_n[31:16] = merge16(sh_m[31:16], wb_dat_i, wb_sel_i);
          end else begin
            sh_f_n[{wi, 4'b0000} +: 16] =
              merge16(sh_f[{wi, 4'b0000} +: 16], wb_dat_i, wb_sel_i);
          end
          mod = |wb_sel_i;
        end
        is_ctrl: if (wb_sel_i[0]) begin
          ac_n = wb_dat_i[CTRL_AUTO];
          if (wb_dat_i[CTRL_CLEAR]) begin
            sh_f_n = '0;
            sh_m_n = '0;
            mod    = 1'b1;
          end
          if (wb_dat_i[CTRL_NL]) begin
            if (!cursor[CUR_W-1]) begin
              cur_n = ROW2_P;
            end else begin
`ifdef LCD_WB_SCROLL_EN
              cur_n  = ROW2_P;
              pend_n = 1'b1;
`else
              cur_n  = '0;
`endif
            end
          end
          commit_n = wb_dat_i[CTRL_COMMIT];
        end
        is_con: if (wb_sel_i[0]) begin
          sh_f_n = nb_f;
          sh_m_n = nb_m;
          mod    = 1'b1;
`ifdef LCD_WB_SCROLL_EN
          if (scroll_pend) begin
            cur_n  = ROW2_P + 5'd1;
            pend_n = 1'b0;
          end else if (&cursor) begin
            cur_n  = ROW2_P;
            pend_n = 1'b1;
          end else begin
            cur_n  = cursor + 5'd1;
          end
`else
          cur_n = cursor + 5'd1;
`endif
        end
        is_cur: if (wb_sel_i[0]) begin
          cur_n = wb_dat_i[CUR_W-1:0];
`ifdef LCD_WB_SCROLL_EN
          pend_n = 1'b0;
`endif
        end
        default: mod = 1'b0;
      endcase
      if (mod) dirty_n = 1'b1;
      if (ac_n && mod) commit_n = 1'b1;
      if (commit_n) dirty_n = 1'b0;
    end
  end

  // Bus FSM: one registered ack per accepted access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BUS_IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      unique case (state)
        BUS_IDLE: if (req) begin
          state    <= BUS_ACK;
          wb_ack_o <= 1'b1;
          wb_dat_o <= rdata;
        end
        BUS_ACK: begin
          state    <= BUS_IDLE;
          wb_ack_o <= 1'b0;
        end
      endcase
    end
  end

  // Shadow, flags, and live copy one cycle after a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_f        <= '0;
      sh_m        <= '0;
      live_f      <= '0;
      live_m      <= '0;
      cursor      <= '0;
      autocommit  <= 1'b0;
      dirty       <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      sh_f        <= sh_f_n;
      sh_m        <= sh_m_n;
      cursor      <= cur_n;
      autocommit  <= ac_n;
      dirty       <= dirty_n;
      commit_pend <= commit_n;
      if (commit_pend) begin
        live_f <= sh_f;
        live_m <= sh_m;
      end
    end
  end

`ifdef LCD_WB_SCROLL_EN
  // Pending scroll after row 2 overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) scroll_pend <= 1'b0;
    else     scroll_pend <= pend_n;
  end
`endif

endmodule

// File: tb/tb_lcd_wb_regs.sv
// Bench for lcd_wb_regs: read scoreboard, vector table, corner sequences.
// Build with LCD_WB_SCROLL_EN to check the scrolling variant.
module tb_lcd_wb_regs;

`ifdef LCD_WB_SCROLL_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0;
  logic [1:0]  sel = '0;
  logic [15:0] dat = '0;
  logic [15:0] dat_o;
  logic        ack;
  logic [63:0] f1, f2;
  logic [15:0] m1, m2;

  always #5 clk = ~clk;

  lcd_wb_regs dut (
    .clk      (clk),
    .rst      (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (dat),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack),
    .f1       (f1),
    .f2       (f2),
    .m1       (m1),
    .m2       (m2)
  );

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;

  typedef struct {
    bit          w;
    logic [3:0]  a;
    logic [1:0]  s;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus access; read data is checked against the scoreboard head.
  task automatic bus(input bit w, input logic [3:0] a,
                     input logic [1:0] s, input logic [15:0] d);
    int   n;
    exp_t e;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; sel = s; dat = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 4);
    chk("ack_latency", 64'(n), 64'd1);
    if (ack) begin
      if (!w) begin
        if (sbq.size() == 0) begin
          chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          chk(e.nm, 64'(dat_o), 64'(e.v));
        end
      end
      tick();
    end else if (!w && sbq.size() != 0) begin
      e = sbq.pop_front();
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus(1'b1, a, 2'b11, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e,
                    input string nm);
    exp_t x;
    x.v = e;
    x.nm = nm;
    sbq.push_back(x);
    bus(1'b0, a, 2'b11, 16'h0);
  endtask

  vec_t        vt[$];
  logic [127:0] ef;
  logic [3:0]  nb;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f1", f1, 64'd0);
    chk("rst_f2", f2, 64'd0);
    chk("rst_m1", 64'(m1), 64'd0);
    chk("rst_m2", 64'(m2), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    rst = 1'b0;
    tick();

    // 1: word writes then explicit commit
    wr(4'h0, 16'h1234);
    wr(4'h8, 16'h000F);
    wr(4'hA, 16'h0001);
    chk("t1_f1_early", f1, 64'd0);
    tick();
    chk("t1_f1", f1, 64'h0000_0000_0000_1234);
    chk("t1_m1", 64'(m1), 64'h000F);
    rd(4'hA, 16'h0000, "t1_ctrl");

    // 2: console with autocommit
    wr(4'hA, 16'h0002);
    wr(4'hC, 16'h0000);
    wr(4'hB, 16'h000A);
    wr(4'hB, 16'h000B);
    wr(4'hB, 16'h000C);
    tick();
    chk("t2_f1", f1, 64'hABC0_0000_0000_1234);
    chk("t2_m1", 64'(m1), 64'hE00F);
    rd(4'hC, 16'd3, "t2_cursor");
    rd(4'hA, 16'h0001, "t2_ctrl");

    // 3: partial lane write, no autocommit
    wr(4'hA, 16'h0000);
    bus(1'b1, 4'h4, 2'b10, 16'hBEEF);
    tick();
    rd(4'h4, 16'hBE00, "t3_shadow");
    chk("t3_live_f2", f2, 64'd0);
    rd(4'hA, 16'h0002, "t3_ctrl");

    // 4: console at the last cell
    wr(4'hA, 16'h0002);
    wr(4'hC, 16'd31);
    wr(4'hB, 16'h0005);
    tick();
    chk("t4_f2", f2, 64'h0000_0000_0000_BE05);
    chk("t4_m2", 64'(m2), 64'h0001);
    rd(4'hC, SCR ? 16'd16 : 16'd0, "t4_cursor");

    // 5: fill all 32 cells, then one more
    wr(4'hA, 16'h0006);
    wr(4'hC, 16'h0000);
    ef = '0;
    for (int p = 0; p < 32; p++) begin
      nb = 4'(p * 3 + 1);
      ef[4 * (31 - p) +: 4] = nb;
      wr(4'hB, {12'd0, nb});
    end
    tick();
    chk("t5_fill_f1", f1, ef[127:64]);
    chk("t5_fill_f2", f2, ef[63:0]);
    rd(4'hC, SCR ? 16'd16 : 16'd0, "t5_cursor_full");
    wr(4'hB, 16'h0007);
    tick();
    if (SCR) begin
      chk("t5_f1", f1, ef[63:0]);
      chk("t5_m1", 64'(m1), 64'hFFFF);
      chk("t5_f2", f2, 64'h7000_0000_0000_0000);
      chk("t5_m2", 64'(m2), 64'h8000);
      rd(4'hC, 16'd17, "t5_cursor");
    end else begin
      ef[127:124] = 4'h7;
      chk("t5_f1", f1, ef[127:64]);
      chk("t5_m1", 64'(m1), 64'hFFFF);
      chk("t5_f2", f2, ef[63:0]);
      chk("t5_m2", 64'(m2), 64'hFFFF);
      rd(4'hC, 16'd1, "t5_cursor");
    end

    // 6: reset inside the ack cycle of a clear
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 4'hA; sel = 2'b11; dat = 16'h0004;
    tick();
    chk("t6_ack_up", 64'(ack), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_ack", 64'(ack), 64'd0);
    chk("t6_f1", f1, 64'd0);
    chk("t6_f2", f2, 64'd0);
    chk("t6_m1", 64'(m1), 64'd0);
    chk("t6_m2", 64'(m2), 64'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    tick();
    rd(4'h0, 16'h0000, "t6_sh_f1");
    rd(4'h5, 16'h0000, "t6_sh_f2");
    rd(4'h8, 16'h0000, "t6_sh_m1");
    rd(4'hC, 16'h0000, "t6_cursor");
    rd(4'hA, 16'h0000, "t6_ctrl");

    // Register map vectors
    vt = '{
      '{1'b1, 4'h1, 2'b11, 16'h1111, 16'h0},
      '{1'b0, 4'h1, 2'b11, 16'h0,    16'h1111},
      '{1'b1, 4'h2, 2'b01, 16'hABCD, 16'h0},
      '{1'b0, 4'h2, 2'b11, 16'h0,    16'h00CD},
      '{1'b1, 4'h3, 2'b10, 16'hABCD, 16'h0},
      '{1'b0, 4'h3, 2'b11, 16'h0,    16'hAB00},
      '{1'b1, 4'h7, 2'b11, 16'h7777, 16'h0},
      '{1'b0, 4'h7, 2'b11, 16'h0,    16'h7777},
      '{1'b1, 4'h9, 2'b11, 16'h5A5A, 16'h0},
      '{1'b1, 4'h9, 2'b00, 16'hFFFF, 16'h0},
      '{1'b0, 4'h9, 2'b11, 16'h0,    16'h5A5A},
      '{1'b1, 4'hD, 2'b11, 16'hFFFF, 16'h0},
      '{1'b0, 4'hD, 2'b11, 16'h0,    16'h0000},
      '{1'b0, 4'hB, 2'b11, 16'h0,    16'h0000},
      '{1'b1, 4'hC, 2'b11, 16'hFFFF, 16'h0},
      '{1'b0, 4'hC, 2'b11, 16'h0,    16'h001F},
      '{1'b1, 4'hC, 2'b11, 16'h0005, 16'h0},
      '{1'b1, 4'hA, 2'b11, 16'h0008, 16'h0},
      '{1'b0, 4'hC, 2'b11, 16'h0,    16'h0010},
      '{1'b1, 4'hA, 2'b11, 16'h0008, 16'h0},
      '{1'b0, 4'hC, 2'b11, 16'h0,    SCR ? 16'h0010 : 16'h0000},
      '{1'b0, 4'hA, 2'b11, 16'h0,    16'h0002}
    };
    foreach (vt[i]) begin
      if (vt[i].w)
        bus(1'b1, vt[i].a, vt[i].s, vt[i].d);
      else
        rd(vt[i].a, vt[i].e, $sformatf("vec%0d_adr%h", i, vt[i].a));
    end
    chk("vec_live_f1", f1, 64'd0);
    wr(4'hA, 16'h0001);
    tick();
    chk("vec_f1", f1, 64'hAB00_00CD_1111_0000);
    chk("vec_f2", f2, 64'h7777_0000_0000_0000);
    chk("vec_m2", 64'(m2), 64'h5A5A);
    rd(4'hA, 16'h0000, "vec_ctrl_clean");

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
